regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Write-back arbiter sitting directly upstream of the 32x32-bit register file; it drives that file's single write port (Write_Register, Write_Data, Reg_Write).
- Merges two result sources:
  - the single-cycle ALU path, which cannot be back-pressured;
  - the variable-latency memory/load path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Guarantees program-order correctness per register, suppresses writes to register 0, and prevents the memory path from starving.

Parameters:
- DATA_WIDTH, 32: width of write data.
- ADDR_WIDTH, 5: width of register index.
- FIFO_DEPTH, 4: memory-path buffer entries; must be a power of 2, at least 2.
- STARVE_LIMIT, 3: number of consecutive cycles the FIFO head may lose arbitration before Stall_Req asserts.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  synchronous reset, active-low.
- Alu_Valid  in  1  ALU result present this cycle.
- Alu_Register  in  ADDR_WIDTH  ALU destination register.
- Alu_Data  in  DATA_WIDTH  ALU result.
- Mem_Valid  in  1  memory result offered.
- Mem_Ready  out  1  FIFO can accept a memory result.
- Mem_Register  in  ADDR_WIDTH  memory destination register.
- Mem_Data  in  DATA_WIDTH  memory result.
- Write_Register  out  ADDR_WIDTH  to register file.
- Write_Data  out  DATA_WIDTH  to register file.
- Reg_Write  out  1  register file write strobe.
- Stall_Req  out  1  request to hold the ALU path upstream.
- Fifo_Count  out  log2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (Rst_n low at a Clk edge), taking precedence over all other activity:
  - Reg_Write=0, Write_Register=0, Write_Data=0, Stall_Req=0.
  - Fifo_Count=0, FIFO pointers=0, starvation counter=0.
  - Mem_Ready=1 from the first cycle after reset.
  - Reset mid-operation discards all buffered entries; no write is issued.
- Outputs Write_*, Reg_Write and Stall_Req are registered.
- Latency:
  - ALU result reaches the write port 1 cycle after Alu_Valid.
  - Memory result: earliest write is 2 cycles after the handshake (push, then pop). There is no bypass.
- Memory handshake:
  - A transfer occurs when Mem_Valid and Mem_Ready are both 1.
  - Mem_Ready = (Fifo_Count < FIFO_DEPTH), computed from registered count only.
  - A pop in the same cycle does not raise Mem_Ready; when full, a simultaneous push and pop is impossible.
  - A push with Mem_Register==0 completes the handshake but is not stored.
- Each FIFO entry holds {register, data, live}. A pushed entry has live=1.
- Arbitration, each cycle:
  - If Alu_Valid: the ALU wins.
  - Otherwise, if the FIFO is non-empty: pop the head. The head issues a write only if live=1 and its register is not 0.
  - Exception when the ALU write targets register 0: no write is issued, Reg_Write=0 next cycle, and the FIFO head is not popped that cycle.
- Ordering rule: when an ALU write to register r is issued, every FIFO entry with register==r has live cleared in the same cycle.
  - This includes an entry pushed in that same cycle.
  - Killed entries still pop normally, with Reg_Write=0 on the pop cycle.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the ALU wins.
  - Clears on any pop or when the FIFO is empty.
  - Stall_Req=1 the cycle after the counter reaches STARVE_LIMIT, and stays high until the head pops.
- While Stall_Req=1:
  - Upstream must drive Alu_Valid=0.
  - If Alu_Valid=1 anyway, the ALU still wins; no data is lost and Stall_Req stays 1. The bench flags this as a protocol violation.
- Fifo_Count updates as count + push - pop. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push into an empty FIFO with no ALU activity: the entry is popped the next cycle, never the same cycle.

Test Plan:
- Reset then idle:
  - Stimulus: hold Rst_n=0 for 2 cycles, release.
  - Response: Reg_Write=0, Mem_Ready=1, Fifo_Count=0, Stall_Req=0.
- ALU only:
  - Stimulus: Alu_Valid with r5 and 0xDEADBEEF.
  - Response: next cycle Reg_Write=1, Write_Register=5, Write_Data=0xDEADBEEF.
  - Stimulus: Alu_Register=0.
  - Response: Reg_Write=0.
- Fill FIFO:
  - Stimulus: 5 back-to-back memory pushes (r1-r5, data 0x11..0x55) while Alu_Valid is held high to r10.
  - Response: Mem_Ready drops after the 4th push and the 5th waits; Fifo_Count=4.
  - Response: after the ALU stops, writes r1..r4 appear in order, then r5.
- Kill on ordering:
  - Stimulus: push r7=0xAAAA, then an ALU write r7=0xBBBB issues before the pop.
  - Response: r7 is written with 0xBBBB only; the FIFO entry pops with Reg_Write=0.
- Starvation:
  - Stimulus: one FIFO entry and Alu_Valid continuously high.
  - Response: Stall_Req=1 after 3 losses plus 1 cycle.
  - Stimulus: drop Alu_Valid.
  - Response: head writes, then Stall_Req=0 the following cycle.
- Reset mid-operation:
  - Stimulus: FIFO holds 3 entries; assert Rst_n=0 for 1 cycle.
  - Response: Fifo_Count=0 and no write from those entries ever appears.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-back arbiter for the register file write port: merges the single-cycle
// ALU path with a FIFO-buffered memory path, keeping per-register program order.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Alu_Valid,
  input  logic [ADDR_WIDTH-1:0]         Alu_Register,
  input  logic [DATA_WIDTH-1:0]         Alu_Data,
  input  logic                          Mem_Valid,
  output logic                          Mem_Ready,
  input  logic [ADDR_WIDTH-1:0]         Mem_Register,
  input  logic [DATA_WIDTH-1:0]         Mem_Data,
  output logic [ADDR_WIDTH-1:0]         Write_Register,
  output logic [DATA_WIDTH-1:0]         Write_Data,
  output logic                          Reg_Write,
  output logic                          Stall_Req,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SW    = $clog2(STARVE_LIMIT + 2);

  logic [ADDR_WIDTH-1:0] entry_reg_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] entry_reg_d  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] entry_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] entry_live_q, entry_live_d;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_register_q, write_register_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  logic mem_ready, fifo_empty, alu_issue, push, pop;

  always_comb begin
    mem_ready  = (count_q < CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    alu_issue  = Alu_Valid && (Alu_Register != '0);
    // ALU always owns the port when valid, including the r0 case that writes nothing
    pop        = !Alu_Valid && !fifo_empty;
    push       = Mem_Valid && mem_ready && (Mem_Register != '0);

    entry_reg_d  = entry_reg_q;
    entry_data_d = entry_data_q;
    entry_live_d = entry_live_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_issue && (entry_reg_q[i] == Alu_Register)) begin
        entry_live_d[i] = 1'b0;
      end
    end

    if (push) begin
      entry_reg_d[wr_ptr_q]  = Mem_Register;
      entry_data_d[wr_ptr_q] = Mem_Data;
      entry_live_d[wr_ptr_q] = !(alu_issue && (Mem_Register == Alu_Register));
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    if (Alu_Valid) begin
      reg_write_d      = alu_issue;
      write_register_d = Alu_Register;
      write_data_d     = Alu_Data;
    end else if (pop) begin
      reg_write_d      = entry_live_q[rd_ptr_q] && (entry_reg_q[rd_ptr_q] != '0);
      write_register_d = entry_reg_q[rd_ptr_q];
      write_data_d     = entry_data_q[rd_ptr_q];
    end

    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (Alu_Valid && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
    // Stall trails the counter by one cycle, so it drops the cycle after the head write
    stall_d = (starve_q >= SW'(STARVE_LIMIT));
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      starve_q         <= '0;
      stall_q          <= 1'b0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      entry_live_q     <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      starve_q         <= starve_d;
      stall_q          <= stall_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      entry_live_q     <= entry_live_d;
    end
  end

  always_ff @(posedge Clk) begin
    entry_reg_q  <= entry_reg_d;
    entry_data_q <= entry_data_d;
  end

  assign Mem_Ready      = mem_ready;
  assign Fifo_Count     = count_q;
  assign Reg_Write      = reg_write_q;
  assign Write_Register = write_register_q;
  assign Write_Data     = write_data_q;
  assign Stall_Req      = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter with a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Alu_Valid;
  logic [4:0]  Alu_Register;
  logic [31:0] Alu_Data;
  logic        Mem_Valid;
  logic        Mem_Ready;
  logic [4:0]  Mem_Register;
  logic [31:0] Mem_Data;
  logic [4:0]  Write_Register;
  logic [31:0] Write_Data;
  logic        Reg_Write;
  logic        Stall_Req;
  logic [2:0]  Fifo_Count;

  int checks = 0;
  int failures = 0;
  int violations = 0;

  always #5 Clk = ~Clk;

  regfile_write_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Alu_Valid(Alu_Valid), .Alu_Register(Alu_Register), .Alu_Data(Alu_Data),
    .Mem_Valid(Mem_Valid), .Mem_Ready(Mem_Ready), .Mem_Register(Mem_Register),
    .Mem_Data(Mem_Data), .Write_Register(Write_Register), .Write_Data(Write_Data),
    .Reg_Write(Reg_Write), .Stall_Req(Stall_Req), .Fifo_Count(Fifo_Count)
  );

  // Reference model: a queue of pending memory results plus the visible outputs.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  bit          exp_we = 0;
  bit          exp_stall = 0;
  logic [4:0]  exp_wr = '0;
  logic [31:0] exp_wd = '0;

  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mr, input logic [31:0] md,
                      input bit rn);
    Alu_Valid = av; Alu_Register = ar; Alu_Data = ad;
    Mem_Valid = mv; Mem_Register = mr; Mem_Data = md;
    Rst_n = rn;
    if (rn && av && Stall_Req === 1'b1) violations++;
    if (!rn) begin
      mq.delete();
      m_starve = 0; exp_we = 0; exp_stall = 0; exp_wr = '0; exp_wd = '0;
    end else begin
      bit ready = (mq.size() < DEPTH);
      bit was_empty = (mq.size() == 0);
      bit popped = !av && !was_empty;
      exp_stall = (m_starve >= LIMIT);
      if (av) begin
        exp_we = (ar != 0); exp_wr = ar; exp_wd = ad;
      end else if (popped) begin
        ent_t h = mq.pop_front();
        exp_we = h.live && (h.r != 0); exp_wr = h.r; exp_wd = h.d;
      end else begin
        exp_we = 0;
      end
      if (popped || was_empty) m_starve = 0;
      else if (av && m_starve < LIMIT) m_starve++;
      if (av && ar != 0)
        foreach (mq[i]) if (mq[i].r == ar) mq[i].live = 0;
      if (mv && ready && mr != 0) begin
        ent_t e;
        e.r = mr; e.d = md; e.live = !(av && ar != 0 && ar == mr);
        mq.push_back(e);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (Reg_Write !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", Reg_Write); end
    checks++; if (Mem_Ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", Mem_Ready); end
    checks++; if (Fifo_Count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Fifo_Count); end
    checks++; if (Stall_Req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall_Req); end
    checks++; if (Write_Register !== 5'd0 || Write_Data !== 32'd0) begin
      failures++; $display("FAIL reset_wdata got=%0d/%h exp=0/0", Write_Register, Write_Data);
    end
    idle(1);
    checks++; if (Reg_Write !== 1'b0 || Mem_Ready !== 1'b1) begin
      failures++; $display("FAIL idle_after_reset got we=%b rdy=%b exp we=0 rdy=1", Reg_Write, Mem_Ready);
    end
  endtask

  task automatic test_alu_only();
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1);
    checks++; if (Reg_Write !== 1'b1 || Write_Register !== 5'd5 || Write_Data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL alu_r5 got we=%b r=%0d d=%h exp we=1 r=5 d=deadbeef", Reg_Write, Write_Register, Write_Data);
    end
    step(1, 5'd0, 32'h12345678, 0, 0, 0, 1);
    checks++; if (Reg_Write !== 1'b0) begin failures++; $display("FAIL alu_r0 got we=%b exp=0", Reg_Write); end
    idle(1);
  endtask

  task automatic test_fill_fifo();
    int n = 0;
    bit pend = 1;
    logic [4:0] r5 = 5'd5;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (Mem_Ready !== 1'b1) begin failures++; $display("FAIL fill_ready%0d got=%b exp=1", i, Mem_Ready); end
      step(1, 5'd10, 32'hA0 + i, 1, 5'(i), 32'(i * 'h11), 1);
    end
    checks++; if (Fifo_Count !== 3'd4 || Mem_Ready !== 1'b0) begin
      failures++; $display("FAIL fill_full got count=%0d rdy=%b exp count=4 rdy=0", Fifo_Count, Mem_Ready);
    end
    step(1, 5'd10, 32'hA5, 1, r5, 32'h55, 1);
    checks++; if (Fifo_Count !== 3'd4) begin failures++; $display("FAIL fill_fifth_waits got=%0d exp=4", Fifo_Count); end
    for (int c = 0; c < 20 && n < 5; c++) begin
      bit rdy = Mem_Ready;
      step(0, 0, 0, pend, r5, 32'h55, 1);
      if (pend && rdy) pend = 0;
      if (Reg_Write === 1'b1) begin
        checks++;
        if (Write_Register !== 5'(n + 1) || Write_Data !== 32'((n + 1) * 'h11)) begin
          failures++; $display("FAIL fill_order%0d got r=%0d d=%h exp r=%0d d=%h", n, Write_Register, Write_Data, n + 1, (n + 1) * 'h11);
        end
        n++;
      end
    end
    checks++; if (n != 5) begin failures++; $display("FAIL fill_drain_timeout got=%0d exp=5 writes", n); end
    idle(2);
  endtask

  task automatic test_kill();
    step(0, 0, 0, 1, 5'd7, 32'hAAAA, 1);
    step(1, 5'd7, 32'hBBBB, 0, 0, 0, 1);
    checks++; if (Reg_Write !== 1'b1 || Write_Register !== 5'd7 || Write_Data !== 32'hBBBB) begin
      failures++; $display("FAIL kill_alu got we=%b r=%0d d=%h exp we=1 r=7 d=bbbb", Reg_Write, Write_Register, Write_Data);
    end
    checks++; if (Fifo_Count !== 3'd1) begin failures++; $display("FAIL kill_held got=%0d exp=1", Fifo_Count); end
    step(0, 0, 0, 0, 0, 0, 1);
    checks++; if (Reg_Write !== 1'b0 || Fifo_Count !== 3'd0) begin
      failures++; $display("FAIL kill_pop got we=%b count=%0d exp we=0 count=0", Reg_Write, Fifo_Count);
    end
    idle(2);
  endtask

  task automatic test_starvation();
    step(1, 5'd9, 32'h9, 1, 5'd3, 32'h33, 1);
    for (int i = 1; i <= 3; i++) step(1, 5'd9, 32'h9, 0, 0, 0, 1);
    checks++; if (Stall_Req !== 1'b0) begin failures++; $display("FAIL starve_early got=%b exp=0", Stall_Req); end
    step(1, 5'd9, 32'h9, 0, 0, 0, 1);
    checks++; if (Stall_Req !== 1'b1) begin failures++; $display("FAIL starve_assert got=%b exp=1", Stall_Req); end
    step(1, 5'd9, 32'h9, 0, 0, 0, 1);
    checks++; if (Stall_Req !== 1'b1 || Fifo_Count !== 3'd1) begin
      failures++; $display("FAIL starve_hold got stall=%b count=%0d exp stall=1 count=1", Stall_Req, Fifo_Count);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    checks++; if (Reg_Write !== 1'b1 || Write_Register !== 5'd3 || Write_Data !== 32'h33) begin
      failures++; $display("FAIL starve_head got we=%b r=%0d d=%h exp we=1 r=3 d=33", Reg_Write, Write_Register, Write_Data);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    checks++; if (Stall_Req !== 1'b0) begin failures++; $display("FAIL starve_release got=%b exp=0", Stall_Req); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1, 5'd20, 32'h20, 1, 5'(11 + i), 32'(i), 1);
    checks++; if (Fifo_Count !== 3'd3) begin failures++; $display("FAIL midrst_fill got=%0d exp=3", Fifo_Count); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (Fifo_Count !== 3'd0 || Reg_Write !== 1'b0) begin
      failures++; $display("FAIL midrst_clear got count=%0d we=%b exp count=0 we=0", Fifo_Count, Reg_Write);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      checks++; if (Reg_Write !== 1'b0) begin failures++; $display("FAIL midrst_nowrite%0d got=%b exp=0", i, Reg_Write); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit av = !exp_stall && ($urandom_range(0, 2) == 0);
      bit rn = ($urandom_range(0, 99) != 0);
      step(av, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom, rn);
      checks++; if (Reg_Write !== exp_we) begin
        failures++; $display("FAIL rand_we c=%0d got=%b exp=%b", c, Reg_Write, exp_we);
      end
      if (exp_we) begin
        checks++; if (Write_Register !== exp_wr || Write_Data !== exp_wd) begin
          failures++; $display("FAIL rand_wdata c=%0d got r=%0d d=%h exp r=%0d d=%h", c, Write_Register, Write_Data, exp_wr, exp_wd);
        end
      end
      checks++; if (Fifo_Count !== 3'(mq.size()) || Mem_Ready !== (mq.size() < DEPTH)) begin
        failures++; $display("FAIL rand_count c=%0d got count=%0d rdy=%b exp count=%0d", c, Fifo_Count, Mem_Ready, mq.size());
      end
      checks++; if (Stall_Req !== exp_stall) begin
        failures++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, Stall_Req, exp_stall);
      end
    end
  endtask

  initial begin
    Rst_n = 1'b0; Alu_Valid = 0; Alu_Register = 0; Alu_Data = 0;
    Mem_Valid = 0; Mem_Register = 0; Mem_Data = 0;
    #1;
    test_reset();
    test_alu_only();
    test_fill_fifo();
    test_kill();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("protocol: Alu_Valid driven during Stall_Req on %0d cycles", violations);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
